// File: rtl/shift_reg_pkg.sv
// Shared types for the shift-register family (PISO serializer and SIPO deserializer).
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_shift_register_if.sv
// Load handshake plus serial output bundle of the PISO serializer.
interface piso_shift_register_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] parallel_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_last;
  logic             busy;

  modport master (
    output parallel_in, load_valid,
    input  load_ready, serial_out, serial_valid, frame_last, busy
  );

  modport slave (
    input  parallel_in, load_valid,
    output load_ready, serial_out, serial_valid, frame_last, busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
// Registered count, zero flag is combinational from the count; no backpressure.
module piso_bit_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_shift_register.sv
// MSB-first serializer, MSB one cycle after accept; optional even-parity bit via PISO_PARITY_EN.
// load_ready only in IDLE or frame_last cycle, so back-to-back frames stream with no gap.
module piso_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                  clk,
  input logic                  reset,
  piso_shift_register_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_out_q, serial_out_d;
  logic             accept;
  logic             cnt_zero;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

`ifdef PISO_PARITY_EN
  assign bus.frame_last = (state_q == PARITY);
`else
  assign bus.frame_last = (state_q == SHIFT) && cnt_zero;
`endif
  assign bus.load_ready   = (state_q == IDLE) || bus.frame_last;
  assign bus.serial_valid = (state_q != IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.serial_out   = serial_out_q;
  assign accept           = bus.load_valid && bus.load_ready;

  piso_bit_counter #(.CW(CW)) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (state_q == SHIFT),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    serial_out_d = serial_out_q;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      SHIFT: begin
        if (!cnt_zero) begin
          serial_out_d = shreg_q[WIDTH-1];
          shreg_d      = shreg_q << 1;
        end else begin
`ifdef PISO_PARITY_EN
          state_d      = PARITY;
          serial_out_d = parity_q;
`else
          state_d      = IDLE;
          serial_out_d = 1'b0;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d      = IDLE;
        serial_out_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
    // An accept in the frame_last cycle overrides the wind-down above.
    if (accept) begin
      state_d      = SHIFT;
      serial_out_d = bus.parallel_in[WIDTH-1];
      shreg_d      = bus.parallel_in << 1;
`ifdef PISO_PARITY_EN
      parity_d     = ^bus.parallel_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      serial_out_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      serial_out_q <= serial_out_d;
`ifdef PISO_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register (WIDTH=4), both with and without PISO_PARITY_EN.
module tb_piso_shift_register;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = 5;
  localparam logic [4:0] F_B = 5'b10111;
  localparam logic [4:0] F_4 = 5'b01001;
  localparam logic [4:0] F_5 = 5'b01010;
  localparam logic [4:0] F_F = 5'b11110;
  localparam logic [4:0] F_3 = 5'b00110;
  localparam logic [4:0] F_7 = 5'b01111;
`else
  localparam int FL = 4;
  localparam logic [4:0] F_B = 5'b01011;
  localparam logic [4:0] F_4 = 5'b00100;
  localparam logic [4:0] F_5 = 5'b00101;
  localparam logic [4:0] F_F = 5'b01111;
  localparam logic [4:0] F_3 = 5'b00011;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] sipo = 4'h0;

  piso_shift_register_if #(.WIDTH(W)) bus ();

  piso_shift_register #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Receive-side deserializer: new bits enter at the LSB.
  always @(posedge clk) begin
    if (bus.serial_valid) sipo <= {sipo[2:0], bus.serial_out};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic exp_bit, input logic exp_last);
    check_val({tag, "_vld"}, 32'(bus.serial_valid), 32'd1);
    check_val({tag, "_bit"}, 32'(bus.serial_out), 32'(exp_bit));
    check_val({tag, "_last"}, 32'(bus.frame_last), 32'(exp_last));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_vld"}, 32'(bus.serial_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_rdy"}, 32'(bus.load_ready), 32'd1);
  endtask

  // Accepts word on the next edge, then checks the whole frame and the idle cycle after it.
  task automatic send_frame(input string tag, input logic [3:0] word, input logic [4:0] exp);
    bus.parallel_in = word;
    bus.load_valid  = 1'b1;
    step();
    bus.load_valid  = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check_bit(tag, exp[FL-1-i], i == FL - 1);
      step();
    end
    check_idle({tag, "_end"});
  endtask

  initial begin
    int n_last;
    logic [9:0] pair;
    bus.parallel_in = 4'hF;
    bus.load_valid  = 1'b1;

    // Reset held with load_valid high: nothing may be accepted.
    step();
    step();
    check_idle("rst_hold");
    check_val("rst_so", 32'(bus.serial_out), 32'd0);
    check_val("rst_last", 32'(bus.frame_last), 32'd0);
    bus.load_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_idle("rst_release");

    send_frame("single_B", 4'hB, F_B);
`ifndef PISO_PARITY_EN
    check_val("loopback_B", 32'(sipo), 32'hB);
`endif

    // Back-to-back: second word held valid from the start of the first frame.
    pair = {F_B, F_4};
    n_last = 0;
    bus.parallel_in = 4'hB;
    bus.load_valid  = 1'b1;
    step();
    bus.parallel_in = 4'h4;
    for (int i = 0; i < 2 * FL; i++) begin
      check_val("b2b_vld", 32'(bus.serial_valid), 32'd1);
      check_val("b2b_bit", 32'(bus.serial_out), 32'(pair[(2 * 5 - 1) - (i / FL) * 5 - (5 - FL) - (i % FL)]));
      if (bus.frame_last) n_last++;
      step();
      if (i == FL - 1) bus.load_valid = 1'b0;
    end
    check_val("b2b_last_cnt", 32'(n_last), 32'd2);
    check_idle("b2b_end");
`ifndef PISO_PARITY_EN
    check_val("loopback_4", 32'(sipo), 32'h4);
`endif

    // Busy ignore: 4'hF presented during bit 2 must wait for frame_last.
    bus.parallel_in = 4'h5;
    bus.load_valid  = 1'b1;
    step();
    bus.load_valid  = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i == 1) begin
        bus.parallel_in = 4'hF;
        bus.load_valid  = 1'b1;
        check_val("ign_rdy_busy", 32'(bus.load_ready), 32'd0);
      end
      check_bit("ign_5", F_5[FL-1-i], i == FL - 1);
      if (i == FL - 1) check_val("ign_rdy_last", 32'(bus.load_ready), 32'd1);
      step();
    end
    bus.load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check_bit("ign_F", F_F[FL-1-i], i == FL - 1);
      step();
    end
    check_idle("ign_end");

    // Reset after two bits of 4'hA drops the frame.
    bus.parallel_in = 4'hA;
    bus.load_valid  = 1'b1;
    step();
    bus.load_valid  = 1'b0;
    check_bit("mid_A0", 1'b1, 1'b0);
    step();
    check_bit("mid_A1", 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle("mid_rst");
    check_val("mid_rst_so", 32'(bus.serial_out), 32'd0);
    check_val("mid_rst_last", 32'(bus.frame_last), 32'd0);
    send_frame("after_rst_3", 4'h3, F_3);

`ifdef PISO_PARITY_EN
    send_frame("parity_7", 4'h7, F_7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
